// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
//   state_t    : scanner FSM states
//   KEY_W      : width of the encoded key code {row_idx, col_idx}
//   COL_RESET  : column drive after reset (column 0)
//   lowest_set : index of the lowest set bit of a 4-bit row pattern
package keypad_pkg;

  typedef enum logic [2:0] {
    SETTLE,
    SAMPLE,
    PRESS_DB,
    REPORT,
    HOLD
  } state_t;

  localparam int unsigned KEY_W     = 4;
  localparam logic [3:0]  COL_RESET = 4'b0001;

  // Multi-row press: the lowest row index wins.
  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    if (v[0]) return 2'd0;
    if (v[1]) return 2'd1;
    if (v[2]) return 2'd2;
    if (v[3]) return 2'd3;
    return 2'd0;
  endfunction

endpackage

// File: rtl/keypad_timer.sv
// Saturating up-counter used for column settle, debounce and key repeat.
//   clock, reset : system clock, asynchronous active-low reset
//   clear        : synchronous clear, has priority over enable
//   enable       : count one step per clock
//   cnt          : current count
//   done         : cnt == LIMIT-1; the counter holds there (no wrap)
module keypad_timer #(
  parameter int unsigned CNT_W = 24,
  parameter int unsigned LIMIT = 2000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  assign done = (cnt == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !done) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad front end: drives columns one-hot, synchronises the rows,
// debounces press and release and emits one key code per accepted press.
//   clock     : system clock
//   reset     : asynchronous, active-low
//   row       : raw keypad rows, active-high, asynchronous to clock
//   col       : column drive, one-hot, active-high
//   key_code  : {row_idx, col_idx} of the last accepted key
//   key_valid : 1-cycle pulse, key_code valid in the same cycle
//   key_held  : high from accepted press until debounced release
// Build option KEY_REPEAT_EN: adds REPEAT_DELAY/REPEAT_PERIOD and re-pulses
// key_valid while the same key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SETTLE_CYC    = 16,
  parameter int unsigned DEBOUNCE_CYC  = 2000000,
`ifdef KEY_REPEAT_EN
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000,
`endif
  parameter int unsigned CNT_W         = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  state_t           state, state_next;
  logic [3:0]       row_m, row_s;
  logic [3:0]       cand;
  logic [1:0]       col_idx;
  logic [CNT_W-1:0] timer_cnt;
  logic             timer_done, timer_clear, timer_en;
  logic             report_now, release_now, rep_fire;

  keypad_timer #(
    .CNT_W (CNT_W),
    .LIMIT (DEBOUNCE_CYC)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .cnt    (timer_cnt),
    .done   (timer_done)
  );

`ifdef KEY_REPEAT_EN
  localparam int unsigned    REP_W     = CNT_W + 2;
  localparam int unsigned    REP_LIMIT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  // Counting starts the cycle after the pulse, and the fire decision is
  // registered into key_valid, hence the -2 / -1 offsets.
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 2);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

  logic             rep_active, rep_first, rep_done;
  logic [REP_W-1:0] rep_cnt;

  assign rep_active = (state == HOLD) && (row_s == cand);
  assign rep_fire   = rep_active && (rep_cnt == (rep_first ? REP_FIRST : REP_NEXT));

  keypad_timer #(
    .CNT_W (REP_W),
    .LIMIT (REP_LIMIT)
  ) u_rep_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (!rep_active || rep_fire || rep_done),
    .enable (rep_active),
    .cnt    (rep_cnt),
    .done   (rep_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rep_first <= 1'b1;
    end else if (!rep_active) begin
      rep_first <= 1'b1;
    end else if (rep_fire) begin
      rep_first <= 1'b0;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= SETTLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    case (state)
      SETTLE: begin
        timer_en = 1'b1;
        if (timer_cnt == SETTLE_LAST) state_next = SAMPLE;
      end
      SAMPLE: begin
        state_next = (row_s == '0) ? SETTLE : PRESS_DB;
      end
      PRESS_DB: begin
        timer_en = 1'b1;
        if (row_s != cand)   state_next = SETTLE;
        else if (timer_done) state_next = REPORT;
      end
      REPORT: begin
        state_next = HOLD;
      end
      HOLD: begin
        if (row_s != '0) begin
          timer_clear = 1'b1;
        end else begin
          timer_en = 1'b1;
          if (timer_done) state_next = SETTLE;
        end
      end
      default: state_next = SETTLE;
    endcase
    if (state_next != state) timer_clear = 1'b1;
  end

  assign report_now  = (state == PRESS_DB) && (state_next == REPORT);
  assign release_now = (state == HOLD) && (state_next == SETTLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_m     <= '0;
      row_s     <= '0;
      col       <= COL_RESET;
      col_idx   <= '0;
      cand      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      row_m <= row;
      row_s <= row_m;
      if (state == SAMPLE) begin
        cand <= row_s;
        if (row_s == '0) begin
          col     <= {col[2:0], col[3]};
          col_idx <= col_idx + 2'd1;
        end
      end
      key_valid <= report_now || rep_fire;
      if (report_now) begin
        key_code <= {lowest_set(cand), col_idx};
        key_held <= 1'b1;
      end else if (release_now) begin
        key_held <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned DEB    = 20;
  localparam int unsigned CW     = 8;
  localparam int          LAT_MAX = 4 * (SETTLE + 1) + 2 + DEB + 1 + 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_held;

  logic [3:0][3:0] keys = '0;
  logic            bounce_off = 1'b0;
  logic [3:0]      row_mask;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [3:0] exp_q[$];
  logic [3:0] obs_code_q[$];
  int         obs_cyc_q[$];

  keypad_scanner #(
    .SETTLE_CYC    (SETTLE),
    .DEBOUNCE_CYC  (DEB),
`ifdef KEY_REPEAT_EN
    .REPEAT_DELAY  (40),
    .REPEAT_PERIOD (10),
`endif
    .CNT_W         (CW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Keypad matrix: a pressed key connects its column line to its row line.
  always_comb begin
    row_mask = '0;
    for (int i = 0; i < 4; i++) if (col[i]) row_mask = row_mask | keys[i];
  end
  assign row = bounce_off ? 4'b0000 : row_mask;

  always @(negedge clock) begin
    if (reset && key_valid) begin
      obs_code_q.push_back(key_code);
      obs_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_pulse(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clock);
      if (obs_code_q.size() != 0) got = 1'b1;
    end
  endtask

  task automatic wait_release(input int budget, output bit got, output int elapsed);
    int t0;
    t0  = cyc;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clock);
      if (key_held === 1'b0) got = 1'b1;
    end
    elapsed = cyc - t0;
  endtask

  task automatic wait_col(input logic [3:0] want, input int budget);
    for (int i = 0; i < budget && col !== want; i++) @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick(3);
    vectors++; if (col !== 4'b0001) begin miscompares++; $display("FAIL reset_col: got %b want 0001", col); end
    vectors++; if (key_code !== 4'h0) begin miscompares++; $display("FAIL reset_code: got %b want 0000", key_code); end
    vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL reset_held: got %b want 0", key_held); end
    reset = 1'b1;
  endtask

  task automatic test_idle_scan;
    logic [3:0] prev;
    int last, nchg;
    prev = col; last = 0; nchg = 0;
    for (int i = 0; i < 45; i++) begin
      tick(1);
      if (col !== prev) begin
        vectors++;
        if (col !== {prev[2:0], prev[3]}) begin
          miscompares++; $display("FAIL idle_rotate: got %b want %b", col, {prev[2:0], prev[3]});
        end
        if (nchg > 0) begin
          vectors++;
          if (cyc - last != SETTLE + 1) begin
            miscompares++; $display("FAIL idle_period: got %0d want %0d", cyc - last, SETTLE + 1);
          end
        end
        last = cyc; prev = col; nchg++;
      end
    end
    vectors++; if (nchg < 8) begin miscompares++; $display("FAIL idle_changes: got %0d want >=8", nchg); end
    vectors++; if (obs_code_q.size() != 0) begin miscompares++; $display("FAIL idle_pulse: got %0d pulses want 0", obs_code_q.size()); end
  endtask

  task automatic test_clean_press;
    bit got; int t_press, t_rel, lat, bad, el; logic [3:0] o, e;
    keys[1] = 4'b0100; exp_q.push_back(4'b1001); t_press = cyc;
    wait_pulse(LAT_MAX + 5, got);
    vectors++;
    if (!got) begin miscompares++; $display("FAIL press_timeout: got no pulse want 1"); return; end
    lat = obs_cyc_q.pop_front(); lat = lat - t_press;
    vectors++; if (lat > LAT_MAX || lat < DEB) begin miscompares++; $display("FAIL press_latency: got %0d want %0d..%0d", lat, DEB, LAT_MAX); end
    o = obs_code_q.pop_front(); e = exp_q.pop_front();
    vectors++; if (o !== e) begin miscompares++; $display("FAIL press_code: got %b want %b", o, e); end
    bad = 0;
    while (cyc - t_press < 100) begin
      tick(1);
      if (key_held !== 1'b1 || col !== 4'b0010) bad++;
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL press_hold: got %0d bad cycles want 0", bad); end
    vectors++; if (obs_code_q.size() != 0) begin miscompares++; $display("FAIL press_extra: got %0d pulses want 0", obs_code_q.size()); end
    keys[1] = 4'b0000; t_rel = cyc;
    tick(15);
    vectors++; if (key_held !== 1'b1) begin miscompares++; $display("FAIL release_early: got %b want 1", key_held); end
    wait_release(30, got, el);
    el = cyc - t_rel;
    vectors++; if (!got || el < DEB + 1 || el > DEB + 3) begin miscompares++; $display("FAIL release_time: got %0d want %0d..%0d", el, DEB + 1, DEB + 3); end
    vectors++; if (key_code !== 4'b1001) begin miscompares++; $display("FAIL code_hold: got %b want 1001", key_code); end
  endtask

  task automatic test_bounce;
    bit got; int t_stable, lat, el; logic [3:0] o, e;
    keys[2] = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      bounce_off = (i % 2) == 1;
      tick(5);
    end
    vectors++; if (obs_code_q.size() != 0) begin miscompares++; $display("FAIL bounce_early: got %0d pulses want 0", obs_code_q.size()); end
    bounce_off = 1'b0; exp_q.push_back(4'b0010); t_stable = cyc;
    wait_pulse(LAT_MAX + 5, got);
    vectors++;
    if (!got) begin miscompares++; $display("FAIL bounce_timeout: got no pulse want 1"); end
    else begin
      lat = obs_cyc_q.pop_front(); lat = lat - t_stable;
      vectors++; if (lat < DEB || lat > LAT_MAX) begin miscompares++; $display("FAIL bounce_latency: got %0d want %0d..%0d", lat, DEB, LAT_MAX); end
      o = obs_code_q.pop_front(); e = exp_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL bounce_code: got %b want %b", o, e); end
    end
    tick(10);
    keys[2] = 4'b0000;
    wait_release(40, got, el);
    vectors++; if (!got || obs_code_q.size() != 0) begin miscompares++; $display("FAIL bounce_release: got held=%b pulses=%0d want 0 0", key_held, obs_code_q.size()); end
  endtask

  task automatic test_multi_row;
    bit got; int el; logic [3:0] o, e;
    keys[3] = 4'b1010; exp_q.push_back(4'b0111);
    wait_pulse(LAT_MAX + 5, got);
    vectors++;
    if (!got) begin miscompares++; $display("FAIL multi_timeout: got no pulse want 1"); end
    else begin
      void'(obs_cyc_q.pop_front());
      o = obs_code_q.pop_front(); e = exp_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL multi_code: got %b want %b", o, e); end
    end
    tick(5);
    keys[3] = 4'b0000;
    wait_release(40, got, el);
    vectors++; if (!got) begin miscompares++; $display("FAIL multi_release: got held=%b want 0", key_held); end
  endtask

  task automatic test_reset_mid_press;
    wait_col(4'b1000, 30);
    keys[0] = 4'b1000;
    wait_col(4'b0001, 30);
    // col just switched: SETTLE 0..3, SAMPLE, then PRESS_DB timer 0.. -> timer=10 after 15 clocks
    tick(15);
    reset = 1'b0;
    #1;
    vectors++; if (col !== 4'b0001) begin miscompares++; $display("FAIL mid_reset_col: got %b want 0001", col); end
    vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL mid_reset_held: got %b want 0", key_held); end
    vectors++; if (key_code !== 4'h0) begin miscompares++; $display("FAIL mid_reset_code: got %b want 0000", key_code); end
    keys[0] = 4'b0000;
    tick(3);
    reset = 1'b1;
    tick(60);
    vectors++; if (obs_code_q.size() != 0) begin miscompares++; $display("FAIL mid_reset_pulse: got %0d pulses want 0", obs_code_q.size()); end
  endtask

`ifdef KEY_REPEAT_EN
  task automatic test_repeat;
    bit got; int t0, el, n, want_off[$]; logic [3:0] o, e;
    keys[2] = 4'b1000;
    want_off = '{0, 40, 50, 60, 70};
    for (int i = 0; i < 5; i++) exp_q.push_back(4'b1110);
    wait_pulse(LAT_MAX + 5, got);
    vectors++;
    if (!got) begin miscompares++; $display("FAIL repeat_timeout: got no pulse want 1"); keys[2] = 4'b0000; return; end
    t0 = obs_cyc_q[0];
    while (cyc < t0 + 75) tick(1);
    keys[2] = 4'b0000;
    wait_release(40, got, el);
    n = obs_code_q.size();
    vectors++; if (n != 5) begin miscompares++; $display("FAIL repeat_count: got %0d want 5", n); end
    for (int i = 0; i < 5 && obs_code_q.size() != 0; i++) begin
      o = obs_code_q.pop_front(); e = exp_q.pop_front();
      el = obs_cyc_q.pop_front(); el = el - t0;
      vectors++; if (o !== e) begin miscompares++; $display("FAIL repeat_code%0d: got %b want %b", i, o, e); end
      vectors++; if (el != want_off[i]) begin miscompares++; $display("FAIL repeat_time%0d: got %0d want %0d", i, el, want_off[i]); end
    end
    exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_idle_scan();
    test_clean_press();
    test_bounce();
    test_multi_row();
    test_reset_mid_press();
`ifdef KEY_REPEAT_EN
    test_repeat();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
